lsu_slave_port: RTL and testbench

Responder (slave) end of the core LSU handshake (req/gnt/rvalid). It accepts one transaction at a time, inserts a configurable number of wait states, and returns read data or a write acknowledge through a one-cycle rvalid pulse. It backs a small byte-enabled scratch register bank, giving the decoder a real endpoint to target. It sits behind one decoded peripheral slot.

---
 rtl/lsu_slave_port.sv | 157 +++++++++++++++
 tb/tb_lsu_slave_port.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_slave_port.sv
// Responder end of the LSU req/gnt/rvalid handshake backing a small byte-enabled scratch register bank.
// One transaction in flight, fixed wait states, one-cycle response strobe.
module lsu_slave_port #(
   parameter int ADDR_W      = 20,
   parameter int NREGS       = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        busy_o
);

   localparam int         IDX_W     = $clog2(NREGS);
   localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t             state_r, state_nxt_s;
   logic [3:0]         wait_cnt_r;
   logic [IDX_W-1:0]   idx_r;
   logic               we_r, rng_r;
   logic [3:0]         be_r;
   logic [31:0]        wdata_r;
   logic [31:0]        regs_r [NREGS];
   logic               rvalid_r, err_r, busy_r;
   logic [31:0]        rdata_r;

   logic               gnt_s, req_rng_s, commit_s, enter_resp_s;
   logic [ADDR_W-1:0]  slot_addr_s;
   logic [IDX_W-1:0]   req_idx_s, lk_idx_s;
   logic               lk_we_s, lk_rng_s;
   logic [31:0]        merged_s, lk_word_s;
   logic               unused_addr_s;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction

   assign unused_addr_s = ^{data_addr_i[31:ADDR_W], data_addr_i[1:0]};
   assign slot_addr_s   = data_addr_i[ADDR_W-1:0];
   assign req_idx_s     = data_addr_i[IDX_W+1:2];
   assign req_rng_s     = ((slot_addr_s >> (IDX_W + 2)) == {ADDR_W{1'b0}});
   assign gnt_s         = data_req_i & ((state_r == S_IDLE) | (state_r == S_RESP));
   assign commit_s      = (state_r == S_RESP) & we_r & rng_r;
   assign merged_s      = merge_bytes(regs_r[idx_r], wdata_r, be_r);

   // Next-state decode; entering RESP is where the response is captured.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (gnt_s) state_nxt_s = ZERO_WAIT ? S_RESP : S_WAIT;
            else       state_nxt_s = S_IDLE;
         end
         S_WAIT: begin
            if (wait_cnt_r == 4'd1) state_nxt_s = S_RESP;
            else                    state_nxt_s = S_WAIT;
         end
         S_RESP: begin
            if (gnt_s) state_nxt_s = ZERO_WAIT ? S_RESP : S_WAIT;
            else       state_nxt_s = S_IDLE;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Response lookup: from WAIT use the latched request, otherwise the one being granted now.
   // A write committing in this same RESP cycle is forwarded so a back-to-back read sees it.
   always_comb begin
      enter_resp_s = (state_nxt_s == S_RESP);
      if (state_r == S_WAIT) begin
         lk_idx_s = idx_r;
         lk_we_s  = we_r;
         lk_rng_s = rng_r;
      end else begin
         lk_idx_s = req_idx_s;
         lk_we_s  = data_we_i;
         lk_rng_s = req_rng_s;
      end
      if (commit_s && (idx_r == lk_idx_s)) lk_word_s = merged_s;
      else                                 lk_word_s = regs_r[lk_idx_s];
   end

   // Handshake state, request latch, wait counter and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         busy_r     <= 1'b0;
         wait_cnt_r <= 4'd0;
         idx_r      <= {IDX_W{1'b0}};
         we_r       <= 1'b0;
         rng_r      <= 1'b0;
         be_r       <= 4'd0;
         wdata_r    <= 32'd0;
         rvalid_r   <= 1'b0;
         err_r      <= 1'b0;
         rdata_r    <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != S_IDLE);
         if (gnt_s) begin
            idx_r      <= req_idx_s;
            we_r       <= data_we_i;
            rng_r      <= req_rng_s;
            be_r       <= data_be_i;
            wdata_r    <= data_wdata_i;
            wait_cnt_r <= WAIT_LD;
         end else if (state_r == S_WAIT) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
         if (enter_resp_s) begin
            rvalid_r <= 1'b1;
            err_r    <= ~lk_rng_s;
            rdata_r  <= (lk_rng_s && !lk_we_s) ? lk_word_s : 32'd0;
         end else begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 32'd0;
         end
      end
   end

   // Register bank; a write lands only in its RESP cycle, so reset there discards it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_r[i] <= 32'd0;
      end else if (commit_s) begin
         regs_r[idx_r] <= merged_s;
      end else begin
         regs_r[idx_r] <= regs_r[idx_r];
      end
   end

   assign data_gnt_o    = gnt_s;
   assign data_rvalid_o = rvalid_r;
   assign data_rdata_o  = rdata_r;
   assign data_err_o    = err_r;
   assign busy_o        = busy_r;

endmodule

// File: tb/tb_lsu_slave_port.sv
// Bench for lsu_slave_port: three instances (2, 0 and 3 wait states) against a sequential
// register-file model; directed spec scenarios followed by random traffic.
module tb_lsu_slave_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [31:0] addr, wdata;
   logic        we;
   logic [3:0]  be;
   logic [2:0]  gnt, rvalid, err, busy;
   logic [31:0] rdata [3];

   int passed = 0;
   int total  = 0;
   logic [31:0] mdl [3][16];

   always #5 clk = ~clk;

   lsu_slave_port #(.ADDR_W(20), .NREGS(16), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .data_req_i(req[0]), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]),
      .data_rdata_o(rdata[0]), .data_err_o(err[0]), .busy_o(busy[0]));
   lsu_slave_port #(.ADDR_W(20), .NREGS(16), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .data_req_i(req[1]), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]),
      .data_rdata_o(rdata[1]), .data_err_o(err[1]), .busy_o(busy[1]));
   lsu_slave_port #(.ADDR_W(20), .NREGS(16), .WAIT_CYCLES(3)) dut2 (
      .clk(clk), .rst(rst), .data_req_i(req[2]), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]),
      .data_rdata_o(rdata[2]), .data_err_o(err[2]), .busy_o(busy[2]));

   function automatic int wc_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 16; i++) mdl[k][i] = 32'd0;
   endtask

   // Sequential semantics: the access sees every earlier write, then applies its own.
   task automatic model_access(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                               input logic [31:0] d, output logic [31:0] exp_d, output logic exp_rng);
      int idx;
      exp_rng = (a[19:0] < 20'd64);
      idx     = int'(a[5:2]);
      exp_d   = exp_rng ? mdl[k][idx] : 32'd0;
      if (exp_rng && w) begin
         for (int i = 0; i < 4; i++)
            if (b[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   task automatic check_resp(input int k, input logic w, input logic rng, input logic [31:0] exp_d);
      chk("rvalid", rvalid[k], 32'd1);
      chk("err", err[k], rng ? 32'd0 : 32'd1);
      if (!w || !rng) chk("rdata", rdata[k], exp_d);
   endtask

   task automatic transact(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                           input logic [31:0] d);
      logic [31:0] exp_d;
      logic        rng;
      int          cyc;
      model_access(k, a, w, b, d, exp_d, rng);
      @(negedge clk);
      addr = a; we = w; be = b; wdata = d; req[k] = 1'b1;
      #1 chk("gnt", gnt[k], 32'd1);
      @(negedge clk);
      req[k] = 1'b0;
      cyc = 0;
      while (rvalid[k] !== 1'b1 && cyc < 20) begin
         chk("busy_wait", busy[k], 32'd1);
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, wc_of(k));
      check_resp(k, w, rng, exp_d);
      chk("busy_resp", busy[k], 32'd1);
      @(negedge clk);
      chk("rvalid_drop", rvalid[k], 32'd0);
      chk("rdata_idle", rdata[k], 32'd0);
      chk("err_idle", err[k], 32'd0);
      chk("busy_idle", busy[k], 32'd0);
   endtask

   logic [31:0] op_a [5];
   logic [31:0] op_d [5];
   logic        op_w [5];
   logic [31:0] e_d  [5];
   logic        e_rng[5];
   logic [31:0] ra;
   int          sel;

   initial begin
      model_clear();
      rst = 1'b1; req = 3'b111; addr = 32'd0; we = 1'b0; be = 4'd0; wdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_gnt", gnt[k], 32'd1);
         chk("rst_rvalid", rvalid[k], 32'd0);
         chk("rst_rdata", rdata[k], 32'd0);
         chk("rst_err", err[k], 32'd0);
         chk("rst_busy", busy[k], 32'd0);
      end
      req = 3'b000;
      #1 chk("gnt_follows_req", {29'd0, gnt}, 32'd0);
      rst = 1'b0;

      // Directed scenarios on the two-wait-state instance
      transact(0, 32'h0000_000C, 1'b0, 4'hF, 32'd0);
      transact(0, 32'h0000_0008, 1'b1, 4'hF, 32'hDEAD_BEEF);
      transact(0, 32'h0000_0008, 1'b0, 4'hF, 32'd0);
      transact(0, 32'h0000_0008, 1'b1, 4'b0101, 32'h1122_3344);
      transact(0, 32'h0000_0008, 1'b0, 4'h0, 32'd0);
      chk("merge_const", mdl[0][2], 32'hDE22_BE44);
      transact(0, 32'h0000_0008, 1'b1, 4'h0, 32'hFFFF_FFFF);
      transact(0, 32'h0000_0008, 1'b0, 4'h0, 32'd0);
      transact(0, 32'h0000_0040, 1'b1, 4'hF, 32'hFFFF_FFFF);
      for (int i = 0; i < 16; i++) transact(0, 32'(i * 4), 1'b0, 4'hF, 32'd0);
      transact(0, 32'h0000_0040, 1'b0, 4'hF, 32'd0);

      // Zero-wait instance: preload, then back-to-back with req held high
      transact(1, 32'h0000_0000, 1'b1, 4'hF, $urandom());
      transact(1, 32'h0000_0004, 1'b1, 4'hF, $urandom());
      transact(1, 32'h0000_0008, 1'b1, 4'hF, $urandom());
      op_a[0] = 32'h14; op_w[0] = 1'b1; op_d[0] = $urandom();
      op_a[1] = 32'h14; op_w[1] = 1'b0; op_d[1] = 32'd0;
      op_a[2] = 32'h00; op_w[2] = 1'b0; op_d[2] = 32'd0;
      op_a[3] = 32'h04; op_w[3] = 1'b0; op_d[3] = 32'd0;
      op_a[4] = 32'h08; op_w[4] = 1'b0; op_d[4] = 32'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) check_resp(1, op_w[i-1], e_rng[i-1], e_d[i-1]);
         addr = op_a[i]; we = op_w[i]; be = 4'hF; wdata = op_d[i]; req[1] = 1'b1;
         model_access(1, op_a[i], op_w[i], 4'hF, op_d[i], e_d[i], e_rng[i]);
         #1 chk("b2b_gnt", gnt[1], 32'd1);
      end
      @(negedge clk);
      check_resp(1, op_w[4], e_rng[4], e_d[4]);
      req[1] = 1'b0;
      @(negedge clk);
      chk("b2b_rvalid_drop", rvalid[1], 32'd0);
      chk("b2b_busy_drop", busy[1], 32'd0);

      // Three-wait instance: reset in the second WAIT cycle aborts the write
      @(negedge clk);
      addr = 32'h10; we = 1'b1; be = 4'hF; wdata = 32'hA5A5_A5A5; req[2] = 1'b1;
      #1 chk("abort_gnt", gnt[2], 32'd1);
      @(negedge clk);
      req[2] = 1'b0;
      chk("abort_busy", busy[2], 32'd1);
      @(negedge clk);
      rst = 1'b1;
      chk("abort_no_rvalid0", rvalid[2], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      chk("abort_busy_clr", busy[2], 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk("abort_no_rvalid", rvalid[2], 32'd0);
         @(negedge clk);
      end
      transact(2, 32'h0000_0010, 1'b0, 4'hF, 32'd0);

      // Random traffic on every instance
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 30; n++) begin
            ra  = $urandom();
            sel = $urandom_range(0, 9);
            if (sel < 8) ra[19:6] = 14'd0;
            else if (ra[19:6] == 14'd0) ra[12] = 1'b1;
            transact(k, ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
